// File: rtl/vga_timing_gen_if.sv
// VGA timing bundle: the pixel-advance enable plus the raster position,
// blanking, sync and frame-tracking outputs shared by the generator and its
// consumers.
interface vga_timing_gen_if;
  logic       pix_en;
  logic [9:0] DrawX;
  logic [9:0] DrawY;
  logic       blank;
  logic       hs;
  logic       vs;
  logic       frame_start;
  logic [7:0] frame_count;

  modport master (
    input  pix_en,
    output DrawX, DrawY, blank, hs, vs, frame_start, frame_count
  );

  modport slave (
    output pix_en,
    input  DrawX, DrawY, blank, hs, vs, frame_start, frame_count
  );
endinterface

// File: rtl/vga_timing_gen.sv
// VGA raster timing generator: horizontal/vertical pixel counters, visible
// area and active-low sync decodes, a frame-start pulse and a frame counter.
// Optional macro VGA_SYNC_PIPE_EN registers blank/hs/vs by one pixel so they
// line up with a registered colour path downstream.
module vga_timing_gen #(
  parameter int unsigned H_VISIBLE = 640,
  parameter int unsigned H_FRONT   = 16,
  parameter int unsigned H_SYNC    = 96,
  parameter int unsigned H_BACK    = 48,
  parameter int unsigned V_VISIBLE = 480,
  parameter int unsigned V_FRONT   = 10,
  parameter int unsigned V_SYNC    = 2,
  parameter int unsigned V_BACK    = 33
) (
  input  logic             vga_clk,
  input  logic             reset,
  vga_timing_gen_if.master vga
);

  localparam int unsigned H_TOTAL = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
  localparam int unsigned V_TOTAL = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;

  localparam logic [9:0] H_LAST       = 10'(H_TOTAL - 1);
  localparam logic [9:0] V_LAST       = 10'(V_TOTAL - 1);
  localparam logic [9:0] H_VIS_END    = 10'(H_VISIBLE);
  localparam logic [9:0] V_VIS_END    = 10'(V_VISIBLE);
  localparam logic [9:0] H_SYNC_START = 10'(H_VISIBLE + H_FRONT);
  localparam logic [9:0] H_SYNC_END   = 10'(H_VISIBLE + H_FRONT + H_SYNC);
  localparam logic [9:0] V_SYNC_START = 10'(V_VISIBLE + V_FRONT);
  localparam logic [9:0] V_SYNC_END   = 10'(V_VISIBLE + V_FRONT + V_SYNC);

  logic [9:0] hc;
  logic [9:0] vc;
  logic [7:0] frame_cnt;
  logic       h_wrap;
  logic       v_wrap;
  logic       blank_c;
  logic       hs_c;
  logic       vs_c;

  assign h_wrap = (hc == H_LAST);
  assign v_wrap = (vc == V_LAST);

  // Raster counters: hc advances every enabled pixel, vc on each hc wrap.
  always_ff @(posedge vga_clk or posedge reset) begin
    if (reset) begin
      hc <= '0;
      vc <= '0;
    end else if (vga.pix_en) begin
      if (h_wrap) begin
        hc <= '0;
        if (v_wrap) vc <= '0;
        else        vc <= vc + 10'd1;
      end else begin
        hc <= hc + 10'd1;
      end
    end
  end

  // Frame counter: bumps on the enabled edge that wraps both counters.
  always_ff @(posedge vga_clk or posedge reset) begin
    if (reset)                             frame_cnt <= '0;
    else if (vga.pix_en && h_wrap && v_wrap) frame_cnt <= frame_cnt + 8'd1;
  end

  // Undelayed visible-area and sync decodes of the counter registers.
  always_comb begin
    blank_c = 1'b0;
    hs_c    = 1'b1;
    vs_c    = 1'b1;
    blank_c = (hc < H_VIS_END) && (vc < V_VIS_END);
    hs_c    = !((hc >= H_SYNC_START) && (hc < H_SYNC_END));
    vs_c    = !((vc >= V_SYNC_START) && (vc < V_SYNC_END));
  end

`ifdef VGA_SYNC_PIPE_EN
  logic blank_q;
  logic hs_q;
  logic vs_q;

  // One-pixel alignment stage for blank/sync, advancing only with pix_en.
  always_ff @(posedge vga_clk or posedge reset) begin
    if (reset) begin
      blank_q <= 1'b0;
      hs_q    <= 1'b1;
      vs_q    <= 1'b1;
    end else if (vga.pix_en) begin
      blank_q <= blank_c;
      hs_q    <= hs_c;
      vs_q    <= vs_c;
    end
  end

  assign vga.blank = blank_q;
  assign vga.hs    = hs_q;
  assign vga.vs    = vs_q;
`else
  assign vga.blank = blank_c;
  assign vga.hs    = hs_c;
  assign vga.vs    = vs_c;
`endif

  assign vga.DrawX       = hc;
  assign vga.DrawY       = vc;
  assign vga.frame_count = frame_cnt;
  // reset masks the pulse so (0,0) held in reset does not read as a frame start.
  assign vga.frame_start = vga.pix_en && !reset && (hc == '0) && (vc == '0);

endmodule
